// File: rtl/cs147_pkg.sv
// Shared constants for the cs147sec05 control path: opcodes, functs, ALU ops,
// CTRL bit positions and FSM state encodings.
package cs147_pkg;

   localparam int unsigned CTRL_W  = 32;
   localparam int unsigned ST_W    = 3;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [ST_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXE    = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_MULI  = 6'h1d;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_PUSH  = 6'h1b;
   localparam logic [5:0] OP_POP   = 6'h1c;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_MUL = 6'h2c;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_MUL  = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_AND  = 4'd6;
   localparam logic [3:0] ALU_OR   = 4'd7;
   localparam logic [3:0] ALU_NOR  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;

   localparam int unsigned B_PC_LOAD   = 0;
   localparam int unsigned B_PC_SEL_1  = 1;
   localparam int unsigned B_PC_SEL_2  = 2;
   localparam int unsigned B_PC_SEL_3  = 3;
   localparam int unsigned B_IR_LOAD   = 4;
   localparam int unsigned B_MEM_R     = 5;
   localparam int unsigned B_MEM_W     = 6;
   localparam int unsigned B_R1_SEL_1  = 7;
   localparam int unsigned B_REG_R     = 8;
   localparam int unsigned B_REG_W     = 9;
   localparam int unsigned B_WA_SEL_1  = 10;
   localparam int unsigned B_WA_SEL_2  = 11;
   localparam int unsigned B_WA_SEL_3  = 12;
   localparam int unsigned B_WD_SEL_1  = 13;
   localparam int unsigned B_WD_SEL_2  = 14;
   localparam int unsigned B_WD_SEL_3  = 15;
   localparam int unsigned B_SP_LOAD   = 16;
   localparam int unsigned B_OP1_SEL_1 = 17;
   localparam int unsigned B_OP2_SEL_1 = 18;
   localparam int unsigned B_OP2_SEL_2 = 19;
   localparam int unsigned B_OP2_SEL_3 = 20;
   localparam int unsigned B_OP2_SEL_4 = 21;
   localparam int unsigned B_ALU_LO    = 22;
   localparam int unsigned B_ALU_HI    = 25;
   localparam int unsigned B_MA_SEL_1  = 26;
   localparam int unsigned B_MA_SEL_2  = 27;
   localparam int unsigned B_MD_SEL_1  = 28;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational CTRL word from {state, instruction, zero}. Each phase's bits
// accumulate so that DECODE/EXE selections stay stable through WB.
module ctrl_decode
   import cs147_pkg::*;
(
   input  logic [ST_W-1:0]    state,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               zero,
   output logic [CTRL_W-1:0]  ctrl_c
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [3:0]        alu_op;
   logic              itype_wr;
   logic [CTRL_W-1:0] dec_bits;
   logic [CTRL_W-1:0] exe_bits;
   logic [CTRL_W-1:0] mem_bits;
   logic [CTRL_W-1:0] wb_bits;
   logic              unused_instr_bits;

   assign opcode            = instruction[31:26];
   assign funct             = instruction[5:0];
   assign unused_instr_bits = ^instruction[25:6];

   // Per-instruction contribution of each phase.
   always_comb begin : classify
      alu_op   = ALU_NONE;
      itype_wr = 1'b0;
      dec_bits = '0;
      exe_bits = '0;
      mem_bits = '0;
      wb_bits  = '0;

      dec_bits[B_REG_R]    = 1'b1;
      wb_bits[B_PC_LOAD]   = 1'b1;
      wb_bits[B_PC_SEL_1]  = 1'b1;
      wb_bits[B_PC_SEL_3]  = 1'b1;
      wb_bits[B_WD_SEL_3]  = 1'b1;

      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_MUL:  alu_op = ALU_MUL;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_NOR:  alu_op = ALU_NOR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  alu_op = ALU_SLL;
               FN_SRL:  alu_op = ALU_SRL;
               FN_JR:   wb_bits[B_PC_SEL_1] = 1'b0;
               default: ;
            endcase
            if (alu_op == ALU_SLL || alu_op == ALU_SRL) begin
               exe_bits[B_OP2_SEL_3] = 1'b1;
               exe_bits[B_OP2_SEL_1] = 1'b1;
            end else if (alu_op != ALU_NONE) begin
               exe_bits[B_OP2_SEL_4] = 1'b1;
            end
            if (alu_op != ALU_NONE) begin
               wb_bits[B_REG_W]    = 1'b1;
               wb_bits[B_WA_SEL_3] = 1'b1;
            end
         end
         OP_ADDI: begin alu_op = ALU_ADD; exe_bits[B_OP2_SEL_2] = 1'b1; itype_wr = 1'b1; end
         OP_MULI: begin alu_op = ALU_MUL; exe_bits[B_OP2_SEL_2] = 1'b1; itype_wr = 1'b1; end
         OP_SLTI: begin alu_op = ALU_SLT; exe_bits[B_OP2_SEL_2] = 1'b1; itype_wr = 1'b1; end
         OP_ANDI: begin alu_op = ALU_AND; itype_wr = 1'b1; end
         OP_ORI:  begin alu_op = ALU_OR;  itype_wr = 1'b1; end
         OP_LUI: begin
            itype_wr            = 1'b1;
            wb_bits[B_WD_SEL_2] = 1'b1;
         end
         OP_LW: begin
            alu_op                = ALU_ADD;
            exe_bits[B_OP2_SEL_2] = 1'b1;
            mem_bits[B_MEM_R]     = 1'b1;
            wb_bits[B_MEM_R]      = 1'b1;
            wb_bits[B_WD_SEL_1]   = 1'b1;
            itype_wr              = 1'b1;
         end
         OP_SW: begin
            alu_op                = ALU_ADD;
            exe_bits[B_OP2_SEL_2] = 1'b1;
            mem_bits[B_MEM_W]     = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            alu_op                = ALU_SUB;
            exe_bits[B_OP2_SEL_4] = 1'b1;
            wb_bits[B_PC_SEL_2]   = (opcode == OP_BEQ) ? zero : ~zero;
         end
         OP_JMP: wb_bits[B_PC_SEL_3] = 1'b0;
         OP_JAL: begin
            wb_bits[B_PC_SEL_3] = 1'b0;
            wb_bits[B_REG_W]    = 1'b1;
            wb_bits[B_WA_SEL_2] = 1'b1;
            wb_bits[B_WD_SEL_3] = 1'b0;
         end
         OP_PUSH: begin
            // Store R0 at the old SP, then SP <= SP - 1.
            dec_bits[B_R1_SEL_1]  = 1'b1;
            dec_bits[B_MD_SEL_1]  = 1'b1;
            alu_op                = ALU_SUB;
            exe_bits[B_OP1_SEL_1] = 1'b1;
            exe_bits[B_OP2_SEL_3] = 1'b1;
            mem_bits[B_MEM_W]     = 1'b1;
            mem_bits[B_MA_SEL_1]  = 1'b1;
            wb_bits[B_SP_LOAD]    = 1'b1;
         end
         OP_POP: begin
            // Load R0 from SP + 1, then SP <= SP + 1.
            alu_op                = ALU_ADD;
            exe_bits[B_OP1_SEL_1] = 1'b1;
            exe_bits[B_OP2_SEL_3] = 1'b1;
            mem_bits[B_MEM_R]     = 1'b1;
            wb_bits[B_MEM_R]      = 1'b1;
            wb_bits[B_REG_W]      = 1'b1;
            wb_bits[B_WD_SEL_1]   = 1'b1;
            wb_bits[B_SP_LOAD]    = 1'b1;
         end
         default: ;
      endcase

      exe_bits[B_ALU_HI:B_ALU_LO] = alu_op;
      if (itype_wr) begin
         wb_bits[B_REG_W]    = 1'b1;
         wb_bits[B_WA_SEL_3] = 1'b1;
         wb_bits[B_WA_SEL_1] = 1'b1;
      end
   end

   // Phase selection; illegal encodings drive an all-zero word.
   always_comb begin : phase_sel
      ctrl_c = '0;
      case (state)
         ST_FETCH: begin
            ctrl_c[B_MEM_R]    = 1'b1;
            ctrl_c[B_IR_LOAD]  = 1'b1;
            ctrl_c[B_MA_SEL_2] = 1'b1;
         end
         ST_DECODE: ctrl_c = dec_bits;
         ST_EXE:    ctrl_c = dec_bits | exe_bits;
         ST_MEM:    ctrl_c = dec_bits | exe_bits | mem_bits;
         ST_WB:     ctrl_c = dec_bits | exe_bits | wb_bits;
         default:   ctrl_c = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Five-state multi-cycle sequencer for the cs147sec05 DATA_PATH; holds the
// state register and forces an idle control word while RST is high.
module control_unit
   import cs147_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               ZERO,
   input  logic [INSTR_W-1:0] INSTRUCTION,
   output logic [CTRL_W-1:0]  CTRL,
   output logic [ST_W-1:0]    STATE
);

   state_e            state_q;
   state_e            state_d;
   logic [CTRL_W-1:0] ctrl_c;

   always_ff @(posedge CLK) begin : state_reg
      if (RST) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXE;
         ST_EXE:    state_d = ST_MEM;
         ST_MEM:    state_d = ST_WB;
         ST_WB:     state_d = ST_FETCH;
         default:   state_d = ST_FETCH;
      endcase
   end

   ctrl_decode u_ctrl_decode (
      .state       (state_q),
      .instruction (INSTRUCTION),
      .zero        (ZERO),
      .ctrl_c      (ctrl_c)
   );

   // Reset aborts the instruction in flight immediately, not at the next edge.
   always_comb begin : outputs
      CTRL  = ctrl_c;
      STATE = state_q;
      if (RST) begin
         CTRL  = '0;
         STATE = ST_FETCH;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions plus random ones, each state
// of each instruction compared against an instruction-level reference model.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic        zero;
   logic [31:0] instruction;
   logic [31:0] ctrl;
   logic [2:0]  state;

   int vectors;
   int miscompares;

   control_unit dut (
      .CLK         (clk),
      .RST         (rst),
      .ZERO        (zero),
      .INSTRUCTION (instruction),
      .CTRL        (ctrl),
      .STATE       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: describe the instruction by what it does, then map to bits.
   function automatic logic [31:0] model_ctrl(input int st, input logic [31:0] ins, input logic z);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] c;
      int alu, op2, mem, dest, wsrc, pcm;
      bit op1_sp, push_dat, sp_ld;
      // op2: 0 zero-ext imm, 1 R2, 2 shamt, 3 sign-ext imm, 4 const 1
      // mem: 0 none, 1 read@ALU, 2 write@ALU, 3 write@old SP, 4 read@SP+1
      // dest: 0 none, 1 rd, 2 rt, 3 R31, 4 R0; wsrc: 0 PC+1, 1 ALU, 2 mem, 3 LUI
      // pcm: 0 PC+1, 1 jr, 2 branch taken, 3 jump
      op = ins[31:26];
      fn = ins[5:0];
      alu = 0; op2 = 0; mem = 0; dest = 0; wsrc = 1; pcm = 0;
      op1_sp = 0; push_dat = 0; sp_ld = 0;
      case (op)
         6'h00: case (fn)
            6'h20: begin alu = 1; op2 = 1; dest = 1; end
            6'h22: begin alu = 2; op2 = 1; dest = 1; end
            6'h2c: begin alu = 3; op2 = 1; dest = 1; end
            6'h24: begin alu = 6; op2 = 1; dest = 1; end
            6'h25: begin alu = 7; op2 = 1; dest = 1; end
            6'h27: begin alu = 8; op2 = 1; dest = 1; end
            6'h2a: begin alu = 9; op2 = 1; dest = 1; end
            6'h01: begin alu = 5; op2 = 2; dest = 1; end
            6'h02: begin alu = 4; op2 = 2; dest = 1; end
            6'h08: pcm = 1;
            default: ;
         endcase
         6'h08: begin alu = 1; op2 = 3; dest = 2; end
         6'h1d: begin alu = 3; op2 = 3; dest = 2; end
         6'h0a: begin alu = 9; op2 = 3; dest = 2; end
         6'h0c: begin alu = 6; op2 = 0; dest = 2; end
         6'h0d: begin alu = 7; op2 = 0; dest = 2; end
         6'h0f: begin dest = 2; wsrc = 3; end
         6'h23: begin alu = 1; op2 = 3; mem = 1; dest = 2; wsrc = 2; end
         6'h2b: begin alu = 1; op2 = 3; mem = 2; end
         6'h04: begin alu = 2; op2 = 1; pcm = z ? 2 : 0; end
         6'h05: begin alu = 2; op2 = 1; pcm = z ? 0 : 2; end
         6'h02: pcm = 3;
         6'h03: begin pcm = 3; dest = 3; wsrc = 0; end
         6'h1b: begin push_dat = 1; alu = 2; op1_sp = 1; op2 = 4; mem = 3; sp_ld = 1; end
         6'h1c: begin alu = 1; op1_sp = 1; op2 = 4; mem = 4; dest = 4; wsrc = 2; sp_ld = 1; end
         default: ;
      endcase

      c = 32'h0;
      if (st == 0) begin
         c[4] = 1'b1; c[5] = 1'b1; c[27] = 1'b1;
      end else if (st <= 4) begin
         c[8] = 1'b1;
         if (push_dat) begin c[7] = 1'b1; c[28] = 1'b1; end
         if (st >= 2) begin
            c[25:22] = 4'(alu);
            c[17] = op1_sp;
            case (op2)
               1: c[21] = 1'b1;
               2: begin c[20] = 1'b1; c[18] = 1'b1; end
               3: c[19] = 1'b1;
               4: c[20] = 1'b1;
               default: ;
            endcase
         end
         if (st == 3) begin
            if (mem == 1 || mem == 4) c[5] = 1'b1;
            if (mem == 2 || mem == 3) c[6] = 1'b1;
            if (mem == 3) c[26] = 1'b1;
         end
         if (st == 4) begin
            if (mem == 1 || mem == 4) c[5] = 1'b1;
            c[0]  = 1'b1;
            c[1]  = (pcm != 1);
            c[2]  = (pcm == 2);
            c[3]  = (pcm != 3);
            c[9]  = (dest != 0);
            c[12] = (dest == 1 || dest == 2);
            c[10] = (dest == 2);
            c[11] = (dest == 3);
            c[15] = (wsrc != 0);
            c[14] = (wsrc == 3);
            c[13] = (wsrc == 2);
            c[16] = sp_ld;
         end
      end
      return c;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  ops [0:14];
      logic [5:0]  fns [0:9];
      logic [31:0] w;
      int          k;
      ops = '{6'h00, 6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h04,
              6'h05, 6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c};
      fns = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08};
      w = $urandom;
      k = $urandom_range(0, 16);
      if (k < 15) w[31:26] = ops[k];
      if (w[31:26] == 6'h00) begin
         k = $urandom_range(0, 11);
         if (k < 10) w[5:0] = fns[k];
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Walk one instruction through all states; abort_at < 5 pulses RST in that state.
   task automatic run_instr(input string tag, input logic [31:0] ins, input int zmode, input int abort_at);
      bit aborted;
      aborted = 1'b0;
      for (int s = 0; s < 5 && !aborted; s++) begin
         instruction = (s == 0) ? $urandom : ins;
         zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
         if (s == abort_at) rst = 1'b1;
         @(negedge clk);
         if (s == abort_at) begin
            check($sformatf("%s rst ctrl", tag), ctrl, 32'h0);
            check($sformatf("%s rst state", tag), 32'(state), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            aborted = 1'b1;
         end else begin
            check($sformatf("%s s%0d ctrl", tag, s), ctrl, model_ctrl(s, instruction, zero));
            check($sformatf("%s s%0d state", tag, s), 32'(state), 32'(s));
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      zero        = 1'b0;
      instruction = 32'h0;

      for (int i = 0; i < 2; i++) begin
         instruction = $urandom;
         zero        = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("reset ctrl", ctrl, 32'h0);
         check("reset state", 32'(state), 32'd0);
         @(posedge clk); #1;
      end
      rst = 1'b0;

      run_instr("add",       32'h0022_1820, -1, 5);
      run_instr("beq_z1",    32'h1022_0003,  1, 5);
      run_instr("beq_z0",    32'h1022_0003,  0, 5);
      run_instr("bne_z0",    32'h1422_0003,  0, 5);
      run_instr("jal",       32'h0C00_0010, -1, 5);
      run_instr("push",      32'h6C00_0000, -1, 5);
      run_instr("pop",       32'h7000_0000, -1, 5);
      run_instr("sw_abort",  32'hAC22_0004, -1, 3);
      run_instr("after_rst", 32'h8C22_0004, -1, 5);
      run_instr("jr",        32'h03E0_0008, -1, 5);
      run_instr("bad_op",    32'hFC00_0000, -1, 5);

      for (int n = 0; n < 60; n++) begin
         run_instr($sformatf("rand%0d", n), rand_instr(), -1,
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
